sprite_pixel_fetch: RTL and testbench
=====================================

Name: sprite_pixel_fetch

Overview:
Per-pixel front end of the palette stage. Takes the VGA scan position, determines whether the current pixel falls inside the animated sprite, and reads the sprite index ROM (synchronous read). It composites the sprite over a background index and emits a 5-bit palette index, with a valid flag and aligned coordinates. The palette colour decoder consumes this output directly.

Parameters:
SPR_W, 32, sprite width in pixels (power of 2)
SPR_H, 32, sprite height in pixels (power of 2)
N_FRAMES, 4, animation frames stored in ROM (power of 2)
FRAME_DIV, 8, video frames per animation step (>=1)
TRANSPARENT, 5'd0, sprite index treated as see-through
ADDR_W, 12, ROM address width; must equal log2(N_FRAMES*SPR_W*SPR_H)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at start of vertical blank
pix_valid  in  1  DrawX/DrawY/bg_index are an active pixel this cycle
DrawX  in  10  scan column 0..639
DrawY  in  10  scan row 0..479
bg_index  in  5  background palette index for this pixel
sprite_x_in  in  10  new sprite left edge
sprite_y_in  in  10  new sprite top edge
pos_wr  in  1  latch sprite_x_in/sprite_y_in as pending position
anim_en  in  1  enable animation stepping
rom_addr  out  ADDR_W  sprite ROM address, combinational from stage 0
rom_data  in  5  ROM index, valid one cycle after rom_addr
pixel_index  out  5  composited palette index
pixel_valid  out  1  pixel_index is an active pixel
out_x  out  10  DrawX delayed to align with pixel_index
out_y  out  10  DrawY delayed to align with pixel_index

Behaviour:
- Reset: active and pending position = 0; pending flag = 0; div counter = 0; anim_frame = 0; all pipeline valids = 0; pixel_index, pixel_valid, out_x, out_y = 0.
- Position shadowing: pos_wr loads the pending registers and sets the pending flag. On frame_start with the flag set, pending is copied to active and the flag clears. If pos_wr and frame_start coincide, the new input values go directly to active and the flag clears. The active position never changes mid-frame.
- Animation: on frame_start with anim_en=1, the div counter increments. At FRAME_DIV-1 it wraps to 0, and anim_frame increments modulo N_FRAMES. With anim_en=0 the counter and anim_frame hold. anim_frame changes only on frame_start.
- Stage 0 (input cycle):
  - hit = pix_valid && DrawX >= sx && DrawX < sx+SPR_W && DrawY >= sy && DrawY < sy+SPR_H.
  - Compares use 11-bit sums; there is no wrap past column 639 or row 479, so a sprite is clipped at the right and bottom edges.
  - rom_addr = anim_frame*SPR_W*SPR_H + (DrawY-sy)*SPR_W + (DrawX-sx) when hit, else 0.
- Stage 1 (registered): hit, bg_index, DrawX, DrawY, pix_valid.
- Stage 2 (output register): pixel_index = (hit1 && rom_data != TRANSPARENT) ? rom_data : bg1. When valid1=0, pixel_index = 0 and pixel_valid = 0.
- Latency: a pixel presented at cycle N appears on the outputs at cycle N+2. Throughput is one pixel per clock; there are no stalls.
- Reset mid-frame flushes the pipeline. The first valid output appears 2 cycles after the first pix_valid following reset.
- Indices 32 and above cannot be produced (5-bit path).

Decomposition:
- Shared package sprite_pkg holds:
  - typedef pal_index_t (logic [4:0])
  - typedef coord_t (logic [9:0])
  - constants SCREEN_W=640, SCREEN_H=480, TRANSPARENT_IDX=0
- Sub-module sprite_anim_ctrl owns the position shadow registers, pending flag, div counter and anim_frame. The top level holds the stage 0–2 pipeline.

Test Plan:
- Assert Reset for 2 cycles -> pixel_valid=0, pixel_index=0, out_x=0, anim_frame=0. Then pix_valid with no sprite hit and bg=5 -> pixel_index=5 two cycles later.
- pos_wr (100,50), then frame_start. DrawX=100,DrawY=50 -> rom_addr=0; rom_data=7 -> pixel_index=7, out_x=100 at N+2. DrawX=131,DrawY=81 -> rom_addr=1023.
- Hit with rom_data=0 and bg=12 -> pixel_index=12. DrawX=132 (miss) with bg=3 -> pixel_index=3, rom_addr=0.
- anim_en=1, FRAME_DIV=8: after 8 frame_start pulses, origin pixel rom_addr=1024. After 32 pulses -> rom_addr=0 (wrap). anim_en=0 -> holds.
- During a frame, pos_wr (200,50) -> pixels at x=100 still hit until the next frame_start, then hit at x=200. With pos_wr and frame_start in the same cycle -> new position is active immediately.
- sx=630, sy=0: DrawX=639,DrawY=0 -> hit, rom_addr=9. DrawX=0,DrawY=0 -> no hit (no wrap).

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite pixel fetch path.
package sprite_pkg;

  typedef logic [4:0] pal_index_t;
  typedef logic [9:0] coord_t;

  localparam int unsigned SCREEN_W        = 640;
  localparam int unsigned SCREEN_H        = 480;
  localparam pal_index_t  TRANSPARENT_IDX = 5'd0;

  // Bit width needed to count 0..v-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Sprite position shadowing and animation frame sequencing. Position and
// animation frame only ever change on frame_start, so they are stable for a
// whole visible frame.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned N_FRAMES  = 4,
  parameter int unsigned FRAME_DIV = 8,
  parameter int unsigned FR_W      = clog2_min1(N_FRAMES)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_start,
  input  logic            pos_wr,
  input  logic            anim_en,
  input  coord_t          sprite_x_in,
  input  coord_t          sprite_y_in,
  output coord_t          sprite_x,
  output coord_t          sprite_y,
  output logic [FR_W-1:0] anim_frame
);

  localparam int unsigned DIV_W = clog2_min1(FRAME_DIV);

  coord_t            act_x_q, act_x_d, act_y_q, act_y_d;
  coord_t            pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic              pend_q, pend_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [FR_W-1:0]   frame_q, frame_d;

  // Next-state: pending position capture, frame-boundary commit, animation step.
  always_comb begin
    act_x_d  = act_x_q;
    act_y_d  = act_y_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    pend_d   = pend_q;
    div_d    = div_q;
    frame_d  = frame_q;

    if (pos_wr) begin
      pend_x_d = sprite_x_in;
      pend_y_d = sprite_y_in;
      pend_d   = 1'b1;
    end

    if (frame_start) begin
      // A write landing on the frame boundary bypasses the shadow registers.
      if (pos_wr) begin
        act_x_d = sprite_x_in;
        act_y_d = sprite_y_in;
        pend_d  = 1'b0;
      end else if (pend_q) begin
        act_x_d = pend_x_q;
        act_y_d = pend_y_q;
        pend_d  = 1'b0;
      end

      if (anim_en) begin
        if (div_q == DIV_W'(FRAME_DIV - 1)) begin
          div_d   = '0;
          frame_d = (frame_q == FR_W'(N_FRAMES - 1)) ? '0 : frame_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      act_x_q  <= '0;
      act_y_q  <= '0;
      pend_x_q <= '0;
      pend_y_q <= '0;
      pend_q   <= 1'b0;
      div_q    <= '0;
      frame_q  <= '0;
    end else begin
      act_x_q  <= act_x_d;
      act_y_q  <= act_y_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      pend_q   <= pend_d;
      div_q    <= div_d;
      frame_q  <= frame_d;
    end
  end

  assign sprite_x   = act_x_q;
  assign sprite_y   = act_y_q;
  assign anim_frame = frame_q;

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Per-pixel sprite hit test, ROM addressing and compositing over background.
// Three stages: stage 0 drives rom_addr combinationally, stage 1 waits for the
// synchronous ROM, stage 2 registers the composited palette index.
module sprite_pixel_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W       = 32,
  parameter int unsigned SPR_H       = 32,
  parameter int unsigned N_FRAMES    = 4,
  parameter int unsigned FRAME_DIV   = 8,
  parameter pal_index_t  TRANSPARENT = TRANSPARENT_IDX,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  coord_t            DrawX,
  input  coord_t            DrawY,
  input  pal_index_t        bg_index,
  input  coord_t            sprite_x_in,
  input  coord_t            sprite_y_in,
  input  logic              pos_wr,
  input  logic              anim_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  pal_index_t        rom_data,
  output pal_index_t        pixel_index,
  output logic              pixel_valid,
  output coord_t            out_x,
  output coord_t            out_y
);

  localparam int unsigned FR_W = clog2_min1(N_FRAMES);

  coord_t          sprite_x, sprite_y;
  logic [FR_W-1:0] anim_frame;

  sprite_anim_ctrl #(
    .N_FRAMES  (N_FRAMES),
    .FRAME_DIV (FRAME_DIV),
    .FR_W      (FR_W)
  ) u_anim_ctrl (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .pos_wr      (pos_wr),
    .anim_en     (anim_en),
    .sprite_x_in (sprite_x_in),
    .sprite_y_in (sprite_y_in),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .anim_frame  (anim_frame)
  );

  logic [10:0] x_ext, y_ext, sx_ext, sy_ext;
  coord_t      dx, dy;
  logic        hit0;

  // Stage 0: 11-bit bounds compare so sprites clip at the screen edge instead of wrapping.
  always_comb begin
    x_ext  = {1'b0, DrawX};
    y_ext  = {1'b0, DrawY};
    sx_ext = {1'b0, sprite_x};
    sy_ext = {1'b0, sprite_y};
    dx     = DrawX - sprite_x;
    dy     = DrawY - sprite_y;
    hit0   = pix_valid
             && (x_ext < 11'(SCREEN_W)) && (y_ext < 11'(SCREEN_H))
             && (x_ext >= sx_ext) && (x_ext < sx_ext + 11'(SPR_W))
             && (y_ext >= sy_ext) && (y_ext < sy_ext + 11'(SPR_H));
    rom_addr = '0;
    if (hit0) begin
      rom_addr = ADDR_W'(anim_frame) * ADDR_W'(SPR_W * SPR_H)
               + ADDR_W'(dy) * ADDR_W'(SPR_W)
               + ADDR_W'(dx);
    end
  end

  logic       hit1_q, valid1_q;
  pal_index_t bg1_q;
  coord_t     x1_q, y1_q;

  // Stage 1: hold pixel context while the ROM read completes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit1_q   <= 1'b0;
      valid1_q <= 1'b0;
      bg1_q    <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
    end else begin
      hit1_q   <= hit0;
      valid1_q <= pix_valid;
      bg1_q    <= bg_index;
      x1_q     <= DrawX;
      y1_q     <= DrawY;
    end
  end

  pal_index_t idx2_q;
  logic       valid2_q;
  coord_t     x2_q, y2_q;

  // Stage 2: composite sprite over background; idle slots emit index 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx2_q   <= '0;
      valid2_q <= 1'b0;
      x2_q     <= '0;
      y2_q     <= '0;
    end else begin
      valid2_q <= valid1_q;
      x2_q     <= x1_q;
      y2_q     <= y1_q;
      if (!valid1_q) begin
        idx2_q <= '0;
      end else if (hit1_q && (rom_data != TRANSPARENT)) begin
        idx2_q <= rom_data;
      end else begin
        idx2_q <= bg1_q;
      end
    end
  end

  assign pixel_index = idx2_q;
  assign pixel_valid = valid2_q;
  assign out_x       = x2_q;
  assign out_y       = y2_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Self-checking bench: behavioural model of position shadowing, animation and
// compositing, plus directed literal expectations and randomized traffic.
module tb_sprite_pixel_fetch;

  localparam int SPR_W     = 32;
  localparam int SPR_H     = 32;
  localparam int N_FRAMES  = 4;
  localparam int FRAME_DIV = 8;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_start = 1'b0, pix_valid = 1'b0, pos_wr = 1'b0, anim_en = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, sprite_x_in = '0, sprite_y_in = '0;
  logic [4:0]  bg_index = '0;
  logic [11:0] rom_addr;
  logic [4:0]  rom_data = '0;
  logic [4:0]  pixel_index;
  logic        pixel_valid;
  logic [9:0]  out_x, out_y;

  always #5 Clk = ~Clk;

  sprite_pixel_fetch dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .bg_index    (bg_index),
    .sprite_x_in (sprite_x_in),
    .sprite_y_in (sprite_y_in),
    .pos_wr      (pos_wr),
    .anim_en     (anim_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pixel_index (pixel_index),
    .pixel_valid (pixel_valid),
    .out_x       (out_x),
    .out_y       (out_y)
  );

  // Sprite ROM: synchronous read, data one cycle after address.
  logic [4:0] rom_mem [0:4095];
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    bit v;
    int idx;
    int x;
    int y;
  } exp_t;

  exp_t exp_now;
  exp_t zero_e;
  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit init_done = 1'b0;

  // Model state as of the most recent clock edge.
  int act_x = 0, act_y = 0, pend_x = 0, pend_y = 0, anim_cnt = 0;
  bit pend = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One input cycle: drive at the falling edge, predict, check rom_addr, advance model.
  task automatic step(input bit pv, input int x, input int y, input int bg, input bit fs,
                      input bit pw, input int sxi, input int syi, input bit ae, input bit rst);
    int  frame;
    int  addr;
    bit  hit;
    int  rv;
    @(negedge Clk);
    Reset       = rst;
    pix_valid   = pv;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    bg_index    = 5'(bg);
    frame_start = fs;
    pos_wr      = pw;
    sprite_x_in = 10'(sxi);
    sprite_y_in = 10'(syi);
    anim_en     = ae;

    frame = (anim_cnt / FRAME_DIV) % N_FRAMES;
    hit   = pv && x >= act_x && x < act_x + SPR_W && y >= act_y && y < act_y + SPR_H;
    addr  = hit ? frame * SPR_W * SPR_H + (y - act_y) * SPR_W + (x - act_x) : 0;
    rv    = int'(rom_mem[addr]);
    if (rst) exp_now = zero_e;
    else begin
      exp_now.v   = pv;
      exp_now.idx = !pv ? 0 : ((hit && rv != 0) ? rv : bg);
      exp_now.x   = x;
      exp_now.y   = y;
    end

    #1;
    if (!rst && init_done) chk("rom_addr", int'(rom_addr), addr);

    if (rst) begin
      act_x = 0; act_y = 0; pend_x = 0; pend_y = 0; pend = 0; anim_cnt = 0;
      init_done = 1'b1;
    end else if (fs) begin
      if (pw) begin
        act_x = sxi; act_y = syi; pend = 0;
      end else if (pend) begin
        act_x = pend_x; act_y = pend_y; pend = 0;
      end
      if (ae) anim_cnt++;
    end else if (pw) begin
      pend_x = sxi; pend_y = syi; pend = 1;
    end
  endtask

  task automatic pix(input int x, input int y, input int bg);
    step(1'b1, x, y, bg, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic ctl(input bit fs, input bit pw, input int sx, input int sy, input bit ae);
    step(1'b0, 0, 0, 0, fs, pw, sx, sy, ae, 1'b0);
  endtask

  task automatic rst_cycle();
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  // Output compare: outputs after an edge belong to the pixel driven two cycles earlier.
  initial begin
    exp_t e;
    zero_e = '{v: 1'b0, idx: 0, x: 0, y: 0};
    forever begin
      @(posedge Clk);
      if (Reset) begin
        q.delete();
        q.push_back(zero_e);
        q.push_back(zero_e);
      end else begin
        q.push_back(exp_now);
      end
      while (q.size() > 3) void'(q.pop_front());
      #1;
      if (init_done && q.size() >= 2) begin
        e = q[q.size() - 2];
        chk("pixel_valid", int'(pixel_valid), int'(e.v));
        chk("pixel_index", int'(pixel_index), e.idx);
        if (e.v) begin
          chk("out_x", int'(out_x), e.x);
          chk("out_y", int'(out_y), e.y);
        end
      end
    end
  end

  initial begin
    int x, y, sx, sy;
    bit fs, pw, ae, pv, rs;

    for (int i = 0; i < 4096; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));

    // Reset held for two cycles.
    rst_cycle();
    rst_cycle();
    @(posedge Clk); #1;
    chk("reset_valid", int'(pixel_valid), 0);
    chk("reset_index", int'(pixel_index), 0);
    chk("reset_out_x", int'(out_x), 0);

    // Background-only pixel (sprite at 0,0 does not cover x=300).
    pix(300, 300, 5);
    idle();
    @(posedge Clk); #1;
    chk("bg_only_index", int'(pixel_index), 5);

    // Move sprite to (100,50) and hit its origin.
    rom_mem[0] = 5'd7;
    ctl(1'b0, 1'b1, 100, 50, 1'b0);
    ctl(1'b1, 1'b0, 0, 0, 1'b0);
    pix(100, 50, 9);
    chk("origin_addr", int'(rom_addr), 0);
    idle();
    @(posedge Clk); #1;
    chk("origin_index", int'(pixel_index), 7);
    chk("origin_out_x", int'(out_x), 100);
    pix(131, 81, 9);
    chk("corner_addr", int'(rom_addr), 1023);

    // Transparent texel shows background; column 132 is outside the sprite.
    rom_mem[5] = 5'd0;
    pix(105, 50, 12);
    pix(132, 50, 3);
    chk("miss_addr", int'(rom_addr), 0);
    @(posedge Clk); #1;
    chk("transparent_index", int'(pixel_index), 12);
    idle();
    @(posedge Clk); #1;
    chk("miss_index", int'(pixel_index), 3);

    // Animation: 8 enabled frame starts per step, 4 frames wrap after 32.
    for (int i = 0; i < 8; i++) ctl(1'b1, 1'b0, 0, 0, 1'b1);
    pix(100, 50, 0);
    chk("anim_step_addr", int'(rom_addr), 1024);
    for (int i = 0; i < 24; i++) ctl(1'b1, 1'b0, 0, 0, 1'b1);
    pix(100, 50, 0);
    chk("anim_wrap_addr", int'(rom_addr), 0);
    for (int i = 0; i < 8; i++) ctl(1'b1, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 16; i++) ctl(1'b1, 1'b0, 0, 0, 1'b0);
    pix(100, 50, 0);
    chk("anim_hold_addr", int'(rom_addr), 1024);

    // Mid-frame position write is deferred to the next frame start.
    ctl(1'b0, 1'b1, 200, 50, 1'b0);
    pix(100, 50, 0);
    chk("deferred_old_hit", int'(rom_addr), 1024);
    ctl(1'b1, 1'b0, 0, 0, 1'b0);
    pix(200, 50, 0);
    chk("committed_new_hit", int'(rom_addr), 1024);
    pix(100, 50, 0);
    chk("committed_old_miss", int'(rom_addr), 0);
    ctl(1'b1, 1'b1, 300, 60, 1'b0);
    pix(301, 60, 0);
    chk("coincident_write_addr", int'(rom_addr), 1025);

    // Right-edge clipping with fresh animation state.
    rst_cycle();
    rom_mem[9] = 5'd17;
    ctl(1'b1, 1'b1, 630, 0, 1'b0);
    pix(639, 0, 2);
    chk("edge_hit_addr", int'(rom_addr), 9);
    pix(0, 0, 4);
    chk("no_wrap_addr", int'(rom_addr), 0);
    @(posedge Clk); #1;
    chk("edge_hit_index", int'(pixel_index), 17);
    idle();
    @(posedge Clk); #1;
    chk("no_wrap_index", int'(pixel_index), 4);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 999) < 3);
      fs = ($urandom_range(0, 19) == 0);
      pw = ($urandom_range(0, 29) == 0);
      ae = ($urandom_range(0, 3) != 0);
      pv = ($urandom_range(0, 7) != 0);
      sx = ($urandom_range(0, 3) == 0) ? 600 + int'($urandom_range(0, 39)) : int'($urandom_range(0, 639));
      sy = ($urandom_range(0, 3) == 0) ? 440 + int'($urandom_range(0, 39)) : int'($urandom_range(0, 479));
      if ($urandom_range(0, 1) == 1) begin
        x = act_x + int'($urandom_range(0, SPR_W + 7)) - 4;
        y = act_y + int'($urandom_range(0, SPR_H + 7)) - 4;
      end else begin
        x = int'($urandom_range(0, 639));
        y = int'($urandom_range(0, 479));
      end
      if (x < 0) x = 0;
      if (x > 639) x = 639;
      if (y < 0) y = 0;
      if (y > 479) y = 479;
      step(pv, x, y, int'($urandom_range(0, 31)), fs, pw, sx, sy, ae, rs);
    end
    idle();
    idle();
    @(posedge Clk); #2;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
